// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the framed serial-to-parallel receiver:
//   - sipo_state_e    : receiver FSM state encoding (IDLE, SHIFT)
//   - SIPO_WIDTH_DEF  : default data word width
//   - sipo_cnt_w()    : bit-counter width for a given frame length
//   - sipo_parity32() : even-parity reduction used for the parity check
// ---------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sipo_state_e;

  localparam int SIPO_WIDTH_DEF = 8;

  // The counter must be able to hold the value FRAME_LEN itself.
  function automatic int sipo_cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  // XOR reduction; callers zero-extend narrower words, which keeps the result.
  function automatic logic sipo_parity32(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// ---------------------------------------------------------------------------
// sipo_frame_rx_if
// Bundles the serial input side and the parallel valid/ready output side of
// sipo_frame_rx.
//   serial_in  : serial data bit
//   serial_en  : serial_in is sampled this cycle
//   start      : current serial_en bit is the first bit of a frame
//   par_out    : last completed word
//   out_valid  : par_out holds an unconsumed word
//   out_ready  : consumer accepts par_out
//   busy       : a frame is partially received
//   overrun    : sticky, a completed word was dropped
//   parity_err : parity status of the word in par_out
// Modports: slave = the receiver, master = upstream driver / downstream consumer.
// ---------------------------------------------------------------------------
interface sipo_frame_rx_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
);

  logic             serial_in;
  logic             serial_en;
  logic             start;
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport slave (
    input  serial_in,
    input  serial_en,
    input  start,
    input  out_ready,
    output par_out,
    output out_valid,
    output busy,
    output overrun,
    output parity_err
  );

  modport master (
    output serial_in,
    output serial_en,
    output start,
    output out_ready,
    input  par_out,
    input  out_valid,
    input  busy,
    input  overrun,
    input  parity_err
  );

endinterface

// File: rtl/sipo_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus received-bit counter for the framed SIPO receiver.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   shift_en_i  : shift bit_in_i into the register this cycle
//   clear_i     : with shift_en_i -> restart (bit_in_i becomes bit 1, count=1)
//                 alone           -> empty the register, count=0
//   bit_in_i    : serial bit
//   data_o      : current shift register contents
//   count_o     : number of bits held in the current frame
// MSB_FIRST=1 shifts left (new bit at LSB), MSB_FIRST=0 shifts right
// (new bit at MSB).
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             bit_in_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] first_s;

  // Shifted value and fresh-frame value for the configured direction.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted_s = {sr_q[WIDTH-2:0], bit_in_i};
      first_s   = {{(WIDTH-1){1'b0}}, bit_in_i};
    end else begin
      shifted_s = {bit_in_i, sr_q[WIDTH-1:1]};
      first_s   = {bit_in_i, {(WIDTH-1){1'b0}}};
    end
  end

  // Next-state selection: restart, clear, shift or hold.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i && shift_en_i) begin
      sr_d  = first_s;
      cnt_d = CNT_W'(1);
    end else if (clear_i) begin
      sr_d  = {WIDTH{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else if (shift_en_i) begin
      sr_d  = shifted_s;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= {WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = sr_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// ---------------------------------------------------------------------------
// sipo_frame_rx
// Framed serial-to-parallel receiver. Assembles WIDTH-bit words from a
// serial bit stream (frames begin with start=1 on a sampled bit) and presents
// each completed word on a valid/ready handshake with sticky overrun.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (discards any partial frame)
//   bus  : sipo_frame_rx_if.slave (serial_in, serial_en, start, out_ready in;
//          par_out, out_valid, busy, overrun, parity_err out)
// Parameters: WIDTH (2..32), MSB_FIRST (1: first bit -> par_out[WIDTH-1]).
// Build option: define SIPO_FRAME_RX_PARITY_EN to receive one trailing
// even-parity bit per frame and report it on parity_err; otherwise
// parity_err is constant 0.
// ---------------------------------------------------------------------------
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst,
  sipo_frame_rx_if.slave bus
);

`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int               CNT_W    = sipo_cnt_w(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  sipo_state_e      state_q, state_d;
  logic             shift_en_s;
  logic             clear_s;
  logic             complete_s;
  logic [WIDTH-1:0] data_s;
  logic [CNT_W-1:0] count_s;
  logic [WIDTH-1:0] word_s;
  logic             perr_s;
  logic             accept_s;

  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en_s),
    .clear_i    (clear_s),
    .bit_in_i   (bus.serial_in),
    .data_o     (data_s),
    .count_o    (count_s)
  );

`ifdef SIPO_FRAME_RX_PARITY_EN
  // Last bit is the parity bit: the data bits are already in the register.
  assign word_s = data_s;
  assign perr_s = sipo_parity32(32'(data_s)) ^ bus.serial_in;
`else
  // Last bit is a data bit, so the word is the register with it shifted in.
  always_comb begin
    if (MSB_FIRST != 0) begin
      word_s = {data_s[WIDTH-2:0], bus.serial_in};
    end else begin
      word_s = {bus.serial_in, data_s[WIDTH-1:1]};
    end
  end
  assign perr_s = 1'b0;
`endif

  // FSM next state and shift-core controls.
  always_comb begin
    state_d    = state_q;
    shift_en_s = 1'b0;
    clear_s    = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.serial_en && bus.start) begin
          shift_en_s = 1'b1;
          clear_s    = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!bus.serial_en) begin
          state_d = ST_SHIFT;
        end else if (bus.start) begin
          // Restart wins over completion: the partial frame is dropped.
          shift_en_s = 1'b1;
          clear_s    = 1'b1;
          state_d    = ST_SHIFT;
        end else if (count_s == LAST_CNT) begin
          complete_s = 1'b1;
          clear_s    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          shift_en_s = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      default: begin
        clear_s = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign accept_s = out_valid_q && bus.out_ready;

  // Output word register, handshake and sticky overrun.
  always_comb begin
    par_out_d    = par_out_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    parity_err_d = parity_err_q;
    if (complete_s) begin
      if (!out_valid_q || accept_s) begin
        par_out_d    = word_s;
        parity_err_d = perr_s;
        out_valid_d  = 1'b1;
      end else begin
        // Consumer still holds the previous word: drop the new one.
        overrun_d = 1'b1;
      end
    end else if (accept_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FSM and output state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      par_out_q    <= {WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_out_q    <= par_out_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.par_out    = par_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame_rx
// Two receivers (MSB_FIRST=1 and MSB_FIRST=0, WIDTH=8) share one stimulus
// stream. A queue-based reference model collects the bits of each frame and
// forms the expected words, handshake state and overrun from them.
// ---------------------------------------------------------------------------
module tb_sipo_frame_rx;
  import sipo_pkg::*;

`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic clk;
  logic rst;
  logic ser_s, en_s, st_s, rdy_s;

  int n_checks;
  int n_fail;

  sipo_frame_rx_if #(.WIDTH(8)) bus_m ();
  sipo_frame_rx_if #(.WIDTH(8)) bus_l ();

  assign bus_m.serial_in = ser_s;
  assign bus_m.serial_en = en_s;
  assign bus_m.start     = st_s;
  assign bus_m.out_ready = rdy_s;
  assign bus_l.serial_in = ser_s;
  assign bus_l.serial_en = en_s;
  assign bus_l.start     = st_s;
  assign bus_l.out_ready = rdy_s;

  sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(1)) u_dut_msb (.clk(clk), .rst(rst), .bus(bus_m));
  sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit       q[$];
  bit       m_busy;
  bit [7:0] e_par_m, e_par_l;
  bit       e_valid, e_ovr, e_perr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    e_par_m = 8'h00;
    e_par_l = 8'h00;
    e_valid = 1'b0;
    e_ovr   = 1'b0;
    e_perr  = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit st, input bit b, input bit rdy);
    bit       acc, done, p;
    bit [7:0] wm, wl;
    acc  = e_valid && rdy;
    done = 1'b0;
    if (en) begin
      if (st) begin
        q.delete();
        q.push_back(b);
        m_busy = 1'b1;
      end else if (m_busy) begin
        q.push_back(b);
        if (q.size() == FRAME_LEN) begin
          done   = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    if (done) begin
      wm = 8'h00;
      wl = 8'h00;
      p  = 1'b0;
      for (int i = 0; i < 8; i++) begin
        wm[7-i] = q[i];
        wl[i]   = q[i];
      end
      for (int i = 0; i < q.size(); i++) p = p ^ q[i];
`ifndef SIPO_FRAME_RX_PARITY_EN
      p = 1'b0;
`endif
      q.delete();
      if (!e_valid || acc) begin
        e_par_m = wm;
        e_par_l = wl;
        e_perr  = p;
        e_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (acc) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("m_par",   32'(bus_m.par_out),    32'(e_par_m));
    check_eq("l_par",   32'(bus_l.par_out),    32'(e_par_l));
    check_eq("m_valid", 32'(bus_m.out_valid),  32'(e_valid));
    check_eq("l_valid", 32'(bus_l.out_valid),  32'(e_valid));
    check_eq("m_busy",  32'(bus_m.busy),       32'(m_busy));
    check_eq("l_busy",  32'(bus_l.busy),       32'(m_busy));
    check_eq("m_ovr",   32'(bus_m.overrun),    32'(e_ovr));
    check_eq("l_ovr",   32'(bus_l.overrun),    32'(e_ovr));
    check_eq("m_perr",  32'(bus_m.parity_err), 32'(e_perr));
    check_eq("l_perr",  32'(bus_l.parity_err), 32'(e_perr));
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check.
  task automatic drive_cycle(input bit en, input bit st, input bit b, input bit rdy);
    en_s  = en;
    st_s  = st;
    ser_s = b;
    rdy_s = rdy;
    @(posedge clk);
    model_step(en, st, b, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  // Sends w first-bit-first from bit 7 down; pbit follows when parity is built in.
  task automatic send_frame(input bit [7:0] w, input bit pbit, input bit rdy);
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, (i == 0), w[7-i], rdy);
`ifdef SIPO_FRAME_RX_PARITY_EN
    drive_cycle(1'b1, 1'b0, pbit, rdy);
`endif
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    ser_s = 1'b0;
    en_s  = 1'b0;
    st_s  = 1'b0;
    rdy_s = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // 8'hA5 on both orderings (palindrome), consumed on the next edge.
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("a5_par_m", 32'(bus_m.par_out), 32'h0000_00A5);
    check_eq("a5_par_l", 32'(bus_l.par_out), 32'h0000_00A5);
    check_eq("a5_valid", 32'(bus_m.out_valid), 32'h0000_0001);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("a5_drop", 32'(bus_m.out_valid), 32'h0000_0000);

    // 8'h01 bit order: lands in LSB for MSB-first, in MSB for LSB-first.
    send_frame(8'h01, 1'b1, 1'b1);
    check_eq("x01_par_m", 32'(bus_m.par_out), 32'h0000_0001);
    check_eq("x01_par_l", 32'(bus_l.par_out), 32'h0000_0080);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: second word dropped while the first waits.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    check_eq("ovr_par_m", 32'(bus_m.par_out), 32'h0000_003C);
    check_eq("ovr_flag", 32'(bus_m.overrun), 32'h0000_0001);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("ovr_valid_drop", 32'(bus_m.out_valid), 32'h0000_0000);
    check_eq("ovr_sticky", 32'(bus_m.overrun), 32'h0000_0001);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    reset_pulse();
    check_outputs();

    // Abort after 4 bits, restart with 8'hF0.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0);
    check_eq("abort_par_m", 32'(bus_m.par_out), 32'h0000_00F0);
    check_eq("abort_par_l", 32'(bus_l.par_out), 32'h0000_000F);
    check_eq("abort_busy", 32'(bus_m.busy), 32'h0000_0000);

    // Asynchronous reset mid-frame with a word pending.
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, (i == 0), 1'b1, 1'b0);
    check_eq("pre_rst_busy", 32'(bus_m.busy), 32'h0000_0001);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(bus_m.busy), 32'h0000_0000);
    check_eq("arst_valid", 32'(bus_m.out_valid), 32'h0000_0000);
    check_eq("arst_par_m", 32'(bus_m.par_out), 32'h0000_0000);
    check_eq("arst_par_l", 32'(bus_l.par_out), 32'h0000_0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    check_eq("nostart_busy", 32'(bus_m.busy), 32'h0000_0000);

`ifdef SIPO_FRAME_RX_PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("par_ok", 32'(bus_m.parity_err), 32'h0000_0000);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1);
    check_eq("par_bad", 32'(bus_m.parity_err), 32'h0000_0001);
    check_eq("par_bad_word", 32'(bus_m.par_out), 32'h0000_00A5);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      if (i == 300) begin
        reset_pulse();
        check_outputs();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
